// File: rtl/conv2_frame_ctrl_if.sv
// Datapath bundle between conv2_frame_ctrl (master), the layer-1 feature-map RAM and conv2 (slave).
// RAM read port, pixel stream to conv2 and the tagged conv2 output strobe.
interface conv2_frame_ctrl_if #(
  parameter int CH = 8
);
  logic          fm_rd_en;
  logic [7:0]    fm_rd_addr;
  logic [CH-1:0] fm_rd_data;
  logic          conv_rst_n;
  logic [CH-1:0] pixel_out;
  logic          conv_valid;
  logic          out_valid;
  logic [3:0]    out_row;
  logic [3:0]    out_col;

  modport master (
    output fm_rd_en, fm_rd_addr, conv_rst_n, pixel_out, out_valid, out_row, out_col,
    input  fm_rd_data, conv_valid
  );

  modport slave (
    input  fm_rd_en, fm_rd_addr, conv_rst_n, pixel_out, out_valid, out_row, out_col,
    output fm_rd_data, conv_valid
  );
endinterface

// File: rtl/conv2_frame_ctrl.sv
// Frame sequencer for conv2: clears the datapath, streams one feature map from RAM, tags and counts outputs.
// Define CONV2_FRAME_CTRL_PERF_EN to build the busy-cycle counter on perf_cycles; otherwise it reads 0.
module conv2_frame_ctrl #(
  parameter int WIDTH   = 13,
  parameter int HEIGHT  = 13,
  parameter int K       = 3,
  parameter int CH      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        perf_cycles,
  conv2_frame_ctrl_if.master bus
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int OUT_W = WIDTH - K + 1;
  localparam int NOUT  = OUT_W * (HEIGHT - K + 1);
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  localparam logic [7:0]       ADDR_LAST = 8'(NPIX - 1);
  localparam logic [6:0]       OUT_FULL  = 7'(NOUT);
  localparam logic [3:0]       COL_LAST  = 4'(OUT_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       addr_cnt;
  logic [6:0]       out_cnt, out_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       row_cnt, col_cnt;
  logic             err_q, pix_vld, conv_en_q;
  logic             start_acc, rd_en, tracking, out_vld;
  logic             accept, excess, frame_full, tmo_hit, err_set;

  assign start_acc   = (state == S_IDLE) && start;
  assign rd_en       = (state == S_CLEAR) || (state == S_FEED);
  assign tracking    = (state == S_FEED) || (state == S_DRAIN);
  assign out_vld     = bus.conv_valid && tracking;
  assign accept      = out_vld && (out_cnt != OUT_FULL);
  assign excess      = out_vld && (out_cnt == OUT_FULL);
  assign out_cnt_nxt = out_cnt + {6'd0, accept};
  assign frame_full  = (out_cnt_nxt == OUT_FULL);
  // A strobe landing on the timeout edge is counted first; it can still complete the frame cleanly.
  assign tmo_hit     = (state == S_DRAIN) && (tmo_cnt == TMO_LAST);
  assign err_set     = excess || (tmo_hit && !frame_full);

  always_comb begin
    // NOTE: next state gets its default before the case, so no path can leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_FEED;
      S_FEED:  if (addr_cnt == ADDR_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (frame_full || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all registers use <= so each one samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      out_cnt   <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
      pix_vld   <= 1'b0;
      conv_en_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_vld   <= rd_en;
      conv_en_q <= 1'b1;
      if (start_acc) begin
        addr_cnt <= '0;
        out_cnt  <= '0;
        row_cnt  <= '0;
        col_cnt  <= '0;
        tmo_cnt  <= '0;
        err_q    <= 1'b0;
      end else begin
        if (rd_en && (addr_cnt != ADDR_LAST)) addr_cnt <= addr_cnt + 8'd1;
        if (accept) begin
          out_cnt <= out_cnt_nxt;
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 4'd1;
          end else begin
            col_cnt <= col_cnt + 4'd1;
          end
        end
        if (state == S_DRAIN) tmo_cnt <= tmo_cnt + 1'b1;
        if (err_set) err_q <= 1'b1;
      end
    end
  end

`ifdef CONV2_FRAME_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign err            = err_q;
  assign bus.fm_rd_en   = rd_en;
  assign bus.fm_rd_addr = rd_en ? addr_cnt : 8'd0;
  // Held low through reset and for the single CLEAR cycle of each frame.
  assign bus.conv_rst_n = conv_en_q && (state != S_CLEAR);
  assign bus.pixel_out  = pix_vld ? bus.fm_rd_data : {CH{1'b0}};
  assign bus.out_valid  = out_vld;
  assign bus.out_row    = row_cnt;
  assign bus.out_col    = col_cnt;
endmodule
